// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with two-word
// blocks, LL/SC link tracking and a halt-triggered flush of dirty sets.
module dcache #(
    parameter int NSETS = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int IW = $clog2(NSETS);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] WB0        = 4'd1;
    localparam logic [3:0] WB1        = 4'd2;
    localparam logic [3:0] ALLOC0     = 4'd3;
    localparam logic [3:0] ALLOC1     = 4'd4;
    localparam logic [3:0] FLUSH_SCAN = 4'd5;
    localparam logic [3:0] FLUSH0     = 4'd6;
    localparam logic [3:0] FLUSH1     = 4'd7;
    localparam logic [3:0] DONE       = 4'd8;

    // Cache state
    logic [3:0]   r_state;
    logic [3:0]   w_next;
    logic [NSETS-1:0] r_valid;
    logic [NSETS-1:0] r_dirty;
    logic [25:0]  r_tag  [NSETS];
    logic [31:0]  r_data [NSETS][2];
    logic         r_link_valid;
    logic [31:0]  r_link_addr;
    logic [IW-1:0] r_scan;
    // Block address ({tag, index}) of the request being serviced by a miss
    logic [28:0]  r_miss_blk;

    // Request decode
    logic          w_req;
    logic [IW-1:0] w_idx;
    logic [25:0]   w_tag;
    logic          w_off;
    logic          w_tag_hit;
    logic          w_link_match;
    logic          w_wr_word;
    logic [IW-1:0] w_m_idx;
    logic [25:0]   w_m_tag;
    logic          w_scan_dirty;
    logic          w_scan_last;

    assign w_req        = dmemREN | dmemWEN;
    assign w_idx        = dmemaddr[3 +: IW];
    assign w_tag        = dmemaddr[31:6];
    assign w_off        = dmemaddr[2];
    assign w_tag_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Link compares word addresses only; the byte bits are masked off
    assign w_link_match = r_link_valid && (((r_link_addr ^ dmemaddr) & ~32'h3) == 32'h0);
    // A hit store writes unless it is an SC whose link does not hold
    assign w_wr_word    = (r_state == IDLE) && !halt && w_req && w_tag_hit &&
                          dmemWEN && (!datomic || w_link_match);
    assign w_m_idx      = r_miss_blk[IW-1:0];
    assign w_m_tag      = r_miss_blk[28:3];
    assign w_scan_dirty = r_valid[r_scan] && r_dirty[r_scan];
    assign w_scan_last  = (r_scan == IW'(NSETS - 1));

    // Next-state and output decode; all outputs are zero outside the states that drive them
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_next   = r_state;
        dhit     = 1'b0;
        dmemload = 32'h0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_next = FLUSH_SCAN;
                end else if (w_req) begin
                    if (w_tag_hit) begin
                        dhit = 1'b1;
                        if (dmemWEN)
                            dmemload = datomic ? {31'h0, w_link_match} : 32'h0;
                        else
                            dmemload = r_data[w_idx][w_off];
                    end else begin
                        w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WB0 : ALLOC0;
                    end
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[w_m_idx], w_m_idx, 1'b0, 2'b00};
                dstore = r_data[w_m_idx][0];
                if (!dwait) w_next = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[w_m_idx], w_m_idx, 1'b1, 2'b00};
                dstore = r_data[w_m_idx][1];
                if (!dwait) w_next = ALLOC0;
            end
            ALLOC0: begin
                dREN  = 1'b1;
                daddr = {w_m_tag, w_m_idx, 1'b0, 2'b00};
                if (!dwait) w_next = ALLOC1;
            end
            ALLOC1: begin
                dREN  = 1'b1;
                daddr = {w_m_tag, w_m_idx, 1'b1, 2'b00};
                if (!dwait) w_next = IDLE;
            end
            FLUSH_SCAN: begin
                if (w_scan_dirty)     w_next = FLUSH0;
                else if (w_scan_last) w_next = DONE;
            end
            FLUSH0: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_scan], r_scan, 1'b0, 2'b00};
                dstore = r_data[r_scan][0];
                if (!dwait) w_next = FLUSH1;
            end
            FLUSH1: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_scan], r_scan, 1'b1, 2'b00};
                dstore = r_data[r_scan][1];
                if (!dwait) w_next = FLUSH_SCAN;
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Control state: FSM, valid/dirty bits, link register, scan index, miss address
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_link_valid <= 1'b0;
            r_link_addr  <= 32'h0;
            r_scan       <= '0;
            r_miss_blk   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_scan <= '0;
                    end else if (w_req) begin
                        if (w_tag_hit) begin
                            if (dmemWEN) begin
                                if (w_wr_word) r_dirty[w_idx] <= 1'b1;
                                // Any SC consumes the link; a plain store to the linked word breaks it
                                if (datomic || w_link_match) r_link_valid <= 1'b0;
                            end else if (datomic) begin
                                r_link_valid <= 1'b1;
                                r_link_addr  <= dmemaddr;
                            end
                        end else begin
                            r_miss_blk <= dmemaddr[31:3];
                        end
                    end
                end
                ALLOC1: begin
                    if (!dwait) begin
                        r_valid[w_m_idx] <= 1'b1;
                        r_dirty[w_m_idx] <= 1'b0;
                    end
                end
                FLUSH_SCAN: begin
                    if (!w_scan_dirty && !w_scan_last) r_scan <= r_scan + 1'b1;
                end
                FLUSH1: begin
                    if (!dwait) r_dirty[r_scan] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: store hits and refill words from memory
    // NOTE: the storage arrays are not reset; valid bits gate every use of their contents.
    always_ff @(posedge CLK) begin
        if (w_wr_word) r_data[w_idx][w_off] <= dmemstore;
        if (r_state == ALLOC0 && !dwait) r_data[w_m_idx][0] <= dload;
        if (r_state == ALLOC1 && !dwait) begin
            r_data[w_m_idx][1] <= dload;
            r_tag[w_m_idx]     <= w_m_tag;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: scoreboard bench for dcache. The reference model is a flat
// word-addressed memory plus one link register; the memory responder applies
// programmable wait states and logs every transfer.
`timescale 1ns/1ps
module tb_dcache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt, dmemREN, dmemWEN, datomic;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic [31:0] dload;
    logic        dwait;

    dcache #(.NSETS(8)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
        .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // ---------------- memory and reference model ----------------
    logic [31:0] mem   [int unsigned];
    logic [31:0] model [int unsigned];
    logic        link_v = 1'b0;
    int unsigned link_a;

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction
    function automatic logic [31:0] mem_rd(input int unsigned w);
        return mem.exists(w) ? mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] model_rd(input int unsigned w);
        return model.exists(w) ? model[w] : init_word(w);
    endfunction

    typedef struct { logic [31:0] addr; logic [31:0] data; } xfer_t;
    xfer_t       wlog[$];
    logic [31:0] rlog[$];

    int fixed_wait = -1;
    int cnt = 0;
    function automatic int next_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
    endfunction

    // Memory responder: decides dwait on the falling edge, so a zero here
    // means the transfer completes at the next rising edge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_store;
    logic [1:0]  prev_ctl;
    always @(negedge CLK) begin
        if (!nRST) begin
            dwait      = 1'b1;
            cnt        = next_wait();
            prev_stall = 1'b0;
        end else if (dREN || dWEN) begin
            check("rw_exclusive", {31'h0, dREN & dWEN}, 32'h0);
            check("daddr_aligned", {30'h0, daddr[1:0]}, 32'h0);
            if (prev_stall) begin
                check("stall_hold_addr", daddr, prev_addr);
                check("stall_hold_store", dstore, prev_store);
                check("stall_hold_ctl", {30'h0, dREN, dWEN}, {30'h0, prev_ctl});
            end
            if (cnt > 0) begin
                cnt--;
                dwait      = 1'b1;
                prev_stall = 1'b1;
                prev_addr  = daddr;
                prev_store = dstore;
                prev_ctl   = {dREN, dWEN};
            end else begin
                dwait      = 1'b0;
                prev_stall = 1'b0;
                if (dREN) begin
                    dload = mem_rd(daddr >> 2);
                    rlog.push_back(daddr);
                end else begin
                    mem[daddr >> 2] = dstore;
                    wlog.push_back('{daddr, dstore});
                end
                cnt = next_wait();
            end
        end else begin
            dwait      = 1'b1;
            cnt        = next_wait();
            prev_stall = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic chk; logic [31:0] data; } exp_t;
    exp_t sb[$];

    always @(negedge CLK) begin
        exp_t e;
        if (nRST && dhit) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_dhit");
            end else begin
                e = sb.pop_front();
                if (e.chk) check("dmemload", dmemload, e.data);
            end
        end
    end

    // Issues one request, predicts its response from the model, waits for dhit.
    task automatic do_req(input logic ren, input logic wen, input logic atm,
                          input logic [31:0] addr, input logic [31:0] data, output int lat);
        exp_t e;
        int unsigned w;
        w = addr >> 2;
        e.chk = 1'b1;
        if (wen) begin
            if (atm) begin
                if (link_v && link_a == w) begin
                    model[w] = data;
                    e.data = 32'h1;
                end else begin
                    e.data = 32'h0;
                end
                link_v = 1'b0;
            end else begin
                model[w] = data;
                e.chk  = 1'b0;
                e.data = 32'h0;
                if (link_v && link_a == w) link_v = 1'b0;
            end
        end else begin
            e.data = model_rd(w);
            if (atm) begin
                link_v = 1'b1;
                link_a = w;
            end
        end
        sb.push_back(e);
        @(posedge CLK); #1;
        dmemREN = ren; dmemWEN = wen; datomic = atm; dmemaddr = addr; dmemstore = data;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!dhit && lat < 500);
        if (!dhit) begin
            fail_now("request_timeout");
            sb.delete();
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        link_v = 1'b0;
        model  = mem;
        sb.delete();
    endtask

    task automatic wait_flushed(input int budget);
        int n;
        n = 0;
        while (!flushed && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("flushed", {31'h0, flushed}, 32'h1);
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int lat;
        logic [31:0] a;
        xfer_t exp_w [4];

        // Reset state, with a request already present on the inputs
        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b1; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = 32'h40; dmemstore = 32'h0; dload = 32'h0;
        #1;
        check("rst_dhit", {31'h0, dhit}, 32'h0);
        check("rst_flushed", {31'h0, flushed}, 32'h0);
        check("rst_dren_dwen", {30'h0, dREN, dWEN}, 32'h0);
        check("rst_daddr", daddr, 32'h0);
        check("rst_dstore", dstore, 32'h0);
        check("rst_dmemload", dmemload, 32'h0);
        do_reset();

        // Cold load of 0x40 with two wait cycles per word
        mem[32'h40 >> 2] = 32'h0000_AAAA;
        mem[32'h44 >> 2] = 32'h0000_BBBB;
        model = mem;
        fixed_wait = 2;
        rlog.delete();
        do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, lat);
        check("cold_load_latency", lat, 8);
        check("cold_load_nreads", rlog.size(), 2);
        if (rlog.size() == 2) begin
            check("cold_read0_addr", rlog[0], 32'h40);
            check("cold_read1_addr", rlog[1], 32'h44);
        end

        // Store hit, then conflicting load forces write-back of the dirty set
        fixed_wait = -1;
        wlog.delete(); rlog.delete();
        do_req(1'b0, 1'b1, 1'b0, 32'h44, 32'h1234_5678, lat);
        check("store_hit_latency", lat, 1);
        do_req(1'b1, 1'b0, 1'b0, 32'h244, 32'h0, lat);
        check("wb_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("wb0_addr", wlog[0].addr, 32'h40);
            check("wb0_data", wlog[0].data, 32'h0000_AAAA);
            check("wb1_addr", wlog[1].addr, 32'h44);
            check("wb1_data", wlog[1].data, 32'h1234_5678);
        end
        check("refill_nreads", rlog.size(), 2);
        if (rlog.size() == 2) begin
            check("refill0_addr", rlog[0], 32'h240);
            check("refill1_addr", rlog[1], 32'h244);
        end

        // LL / SC success, then SC without a link fails
        do_req(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, lat);
        do_req(1'b0, 1'b1, 1'b1, 32'h80, 32'd7, lat);
        do_req(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, lat);
        do_req(1'b0, 1'b1, 1'b1, 32'h80, 32'd9, lat);
        do_req(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, lat);

        // A plain store to the linked word breaks the link
        do_req(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, lat);
        do_req(1'b0, 1'b1, 1'b0, 32'h80, 32'h55, lat);
        do_req(1'b0, 1'b1, 1'b1, 32'h80, 32'h66, lat);
        do_req(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, lat);

        // Reset asserted while ALLOC0 is stalled on memory
        fixed_wait = 5;
        @(posedge CLK); #1;
        dmemREN = 1'b1; dmemaddr = 32'h300;
        lat = 0;
        while (!dREN && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        check("alloc_started", {31'h0, dREN}, 32'h1);
        #2 nRST = 1'b0;
        #1;
        check("midmiss_rst_dren_dwen", {30'h0, dREN, dWEN}, 32'h0);
        check("midmiss_rst_daddr", daddr, 32'h0);
        check("midmiss_rst_dhit", {31'h0, dhit}, 32'h0);
        check("midmiss_rst_dmemload", dmemload, 32'h0);
        dmemREN = 1'b0;
        do_reset();
        fixed_wait = -1;
        rlog.delete();
        do_req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, lat);
        check("post_rst_miss_nreads", rlog.size(), 2);
        if (rlog.size() > 0) check("post_rst_read0_addr", rlog[0], 32'h300);

        // Flush of dirty sets 1 and 5, with a hitting request present as halt rises
        do_reset();
        do_req(1'b0, 1'b1, 1'b0, 32'h08, 32'h1111_0001, lat);
        do_req(1'b0, 1'b1, 1'b0, 32'h2C, 32'h2222_0005, lat);
        exp_w[0] = '{32'h08, model_rd(32'h08 >> 2)};
        exp_w[1] = '{32'h0C, model_rd(32'h0C >> 2)};
        exp_w[2] = '{32'h28, model_rd(32'h28 >> 2)};
        exp_w[3] = '{32'h2C, model_rd(32'h2C >> 2)};
        wlog.delete();
        @(posedge CLK); #1;
        halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h08;
        wait_flushed(500);
        check("flush_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                check($sformatf("flush%0d_addr", i), wlog[i].addr, exp_w[i].addr);
                check($sformatf("flush%0d_data", i), wlog[i].data, exp_w[i].data);
            end
        end
        halt = 1'b0;
        dmemWEN = 1'b1; dmemaddr = 32'h2C;
        repeat (10) @(negedge CLK);
        check("done_dhit", {31'h0, dhit}, 32'h0);
        check("done_flushed_sticky", {31'h0, flushed}, 32'h1);
        check("done_dren_dwen", {30'h0, dREN, dWEN}, 32'h0);
        dmemREN = 1'b0; dmemWEN = 1'b0;

        // Randomized traffic over a small footprint, then flush and compare memory
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [25:0] tg;
            tg = ($urandom_range(0, 9) == 0) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
            a  = {tg, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            op = int'($urandom_range(0, 9));
            if (op >= 8 && link_v && $urandom_range(0, 1) == 1) a = {link_a[29:0], 2'b00};
            case (op)
                0, 1, 2, 3: do_req(1'b1, 1'b0, 1'b0, a, 32'h0, lat);
                4, 5, 6:    do_req(1'b0, 1'b1, 1'b0, a, $urandom, lat);
                7:          do_req(1'b1, 1'b0, 1'b1, a, 32'h0, lat);
                8:          do_req(1'b0, 1'b1, 1'b1, a, $urandom, lat);
                default:    do_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, lat);
            endcase
        end
        @(posedge CLK); #1 halt = 1'b1;
        wait_flushed(5000);
        foreach (model[k]) check($sformatf("final_mem_%h", k << 2), mem_rd(k), model[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter: NSETS, 8, number of direct-mapped sets; block size is fixed at 2 words.
REQ-002 Port: CLK  in  1  clock; all state updates on rising edge.
REQ-003 Port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 Port: halt  in  1  datapath halted; starts the flush sequence.
REQ-005 Port: dmemREN  in  1  datapath load request.
REQ-006 Port: dmemWEN  in  1  datapath store request.
REQ-007 Port: datomic  in  1  qualifies REN as LL and WEN as SC.
REQ-008 Port: dmemaddr  in  32  word address; tag [31:6], index [5:3], block offset [2], bits [1:0] ignored.
REQ-009 Port: dmemstore  in  32  store data.
REQ-010 Port: dhit  out  1  request satisfied this cycle.
REQ-011 Port: dmemload  out  32  load data, or the SC result.
REQ-012 Port: flushed  out  1  flush complete; sticky until reset.
REQ-013 Port: dREN  out  1  memory read request.
REQ-014 Port: dWEN  out  1  memory write request.
REQ-015 Port: daddr  out  32  memory word address; bits [1:0] are 0.
REQ-016 Port: dstore  out  32  memory write data.
REQ-017 Port: dload  in  32  memory read data.
REQ-018 Port: dwait  in  1  memory busy; a transfer completes in the first cycle dwait=0 while dREN or dWEN is asserted.

Function
REQ-019 Organisation and policy:
- Direct-mapped, write-back, write-allocate.
- Per set: valid, dirty, 26-bit tag, 2 data words.
REQ-020 FSM states: IDLE, WB0, WB1, ALLOC0, ALLOC1, FLUSH_SCAN, FLUSH0, FLUSH1, DONE.
REQ-021 Hit condition: in IDLE with REN or WEN, a hit is valid && tag match.
REQ-022 Load hit:
- dhit=1 combinationally in the same cycle.
- dmemload = selected word.
REQ-023 Store hit:
- dhit=1 in the same cycle.
- The word is written and dirty is set at the clock edge.
REQ-024 Miss on a dirty set: IDLE -> WB0 -> WB1 -> ALLOC0 -> ALLOC1 -> IDLE.
REQ-025 Miss on a clean or invalid set: IDLE -> ALLOC0 -> ALLOC1 -> IDLE.
REQ-026 Miss response: dhit=0 throughout the miss; the retried request hits in IDLE the cycle after ALLOC1 completes.
REQ-027 Write-back addressing:
- WB0 writes word 0 of the victim to {old tag, index, 0, 00}.
- WB1 writes word 1 to {old tag, index, 1, 00}.
REQ-028 Allocation:
- ALLOC0 and ALLOC1 read words 0 and 1 of the requested block.
- At the ALLOC1 completion edge the set is marked valid, clean, with the new tag.
REQ-029 Memory-stall rule: each memory state holds dREN/dWEN, daddr and dstore stable while dwait=1, and advances only on dwait=0.
REQ-030 Mutual exclusion: dREN and dWEN are never both 1.
REQ-031 Idle outputs: dREN and dWEN are 0 in IDLE and DONE.
REQ-032 LL: on an LL hit, load the word and set link valid with link address = dmemaddr[31:2].
REQ-033 SC success (link valid and address match):
- Perform the store.
- dmemload=1.
- Clear link.
REQ-034 SC failure:
- No store and no dirty change.
- dmemload=0 and dhit=1.
- Clear link.
REQ-035 SC miss handling: an SC miss with a valid matching link allocates the block first; the SC is then evaluated on the retried hit.
REQ-036 Link invalidation: any non-atomic store hit whose word address matches the link address clears link.
REQ-037 Simultaneous REN and WEN: treated as WEN.
REQ-038 halt=1 in IDLE, with or without a request pending: enter FLUSH_SCAN with scan index 0; no dhit is issued.
REQ-039 FLUSH_SCAN, current index dirty: FLUSH0 -> FLUSH1 writes both words, clears dirty, returns to FLUSH_SCAN.
REQ-040 FLUSH_SCAN, current index clean: increment the index.
REQ-041 Flush completion: after index NSETS-1, go to DONE.
REQ-042 DONE: flushed=1; ignore all requests with dhit=0; stay in DONE until reset.
REQ-043 halt asserted during a miss: the current miss sequence completes to IDLE before the flush starts.

Reset
REQ-044 nRST=0 immediately forces:
- State IDLE; all valid and dirty bits 0; link invalid; scan index 0.
- flushed, dREN, dWEN, dhit = 0; daddr, dstore, dmemload = 0.
REQ-045 Reset mid-miss or mid-flush: the memory transaction is abandoned, with no partial update of tag or valid.

Verification
REQ-046 Load 0x40 cold, memory returns 0xAAAA/0xBBBB with dwait=1 for 2 cycles each -> reads at 0x40 and 0x44; the next cycle gives dhit=1, dmemload=0xAAAA.
REQ-047 Store 0x12345678 to 0x44 (hit), then load 0x244 (same index, different tag) -> WB writes 0x40=0xAAAA and 0x44=0x12345678, then reads 0x240 and 0x244.
REQ-048 LL 0x80, SC 0x80 data 7 -> dmemload=1 and the word becomes 7; a second SC to 0x80 gives dmemload=0 and the word stays 7.
REQ-049 LL 0x80, store to 0x80, SC 0x80 -> SC fails with dmemload=0.
REQ-050 Dirty sets 1 and 5, halt=1 -> exactly 4 memory writes, in order set1 w0, w1, set5 w0, w1; then flushed=1 and requests get dhit=0.
REQ-051 Assert nRST=0 during ALLOC0 -> all outputs 0 at once; a subsequent load of the same address misses again.
